im2col_sequencer: RTL and testbench

IM2COL_SEQUENCER -- requirements
Module: im2col_sequencer

---
 rtl/im2col_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_im2col_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_sequencer.sv
`default_nettype none
// ============================================================================
// im2col_sequencer
//   Control FSM that sequences im2col conversion, systolic slice loads and
//   weight-tile reads for CONV / MVM / POOL jobs, with a wait-state watchdog.
//   Revision: 1.0
// ============================================================================

module im2col_sequencer #(
  parameter int SLICE_W = 16,
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic               i_clk,
  input  logic               i_n_reset,
  input  logic               i_set_param,
  input  logic               i_start_mac,
  input  logic               i_start_pool,
  input  logic               i_terminate,
  input  logic [1:0]         i_op_mode,
  input  logic [SLICE_W-1:0] i_slice_number,
  input  logic [TILE_W-1:0]  i_tile_number,
  input  logic               i_i2c_set_param_done,
  input  logic               i_i2s_set_param_done,
  input  logic               i_i2c_convert_done,
  input  logic               i_i2c_slice_read_done,
  input  logic               i_i2c_read_done,
  input  logic               i_i2s_read_done,
  output logic               o_i2c_set_param,
  output logic               o_i2s_set_param,
  output logic               o_i2c_enable,
  output logic               o_i2c_read,
  output logic               o_i2s_enable,
  output logic               o_i2s_read,
  output logic               o_en_ram,
  output logic               o_im2col_addressing,
  output logic               o_image_ready,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_error,
  output logic [SLICE_W-1:0] o_slice_idx,
  output logic [TILE_W-1:0]  o_tile_idx
);

  // Mode bit 1 selects the systolic (i2s) path, bit 0 selects im2col addressing.
  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_POOL = 2'b01;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_PARAM, S_CONVERT, S_SYS, S_WAIT,
    S_READ, S_CHECK, S_POOL, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic i2c_set_param;
    logic i2s_set_param;
    logic i2c_enable;
    logic i2c_read;
    logic i2s_enable;
    logic i2s_read;
    logic en_ram;
    logic im2col_addressing;
    logic image_ready;
    logic done;
    logic busy;
    logic error;
  } ctrl_t;

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [1:0]         mode_q, mode_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d, slice_idx_q, slice_idx_d;
  logic [TILE_W-1:0]  tile_cnt_q, tile_cnt_d, tile_idx_q, tile_idx_d;
  logic               c_flag_q, c_flag_d, s_flag_q, s_flag_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               w_timeout, w_watched, w_wd_fire;

  assign w_wd_fire = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    ctrl_d.done = 1'b0;
    mode_d      = mode_q;
    slice_cnt_d = slice_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    slice_idx_d = slice_idx_q;
    tile_idx_d  = tile_idx_q;
    c_flag_d    = c_flag_q;
    s_flag_d    = s_flag_q;
    w_timeout   = 1'b0;
    w_watched   = state_q inside {S_SET_PARAM, S_CONVERT, S_SYS, S_READ, S_POOL};

    if (i_terminate && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      ctrl_d      = '0;
      slice_idx_d = '0;
      tile_idx_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_set_param && (i_op_mode != MODE_NOP)) begin
            state_d              = S_SET_PARAM;
            mode_d               = i_op_mode;
            slice_cnt_d          = (i_slice_number == '0) ? SLICE_W'(1) : i_slice_number;
            tile_cnt_d           = (i_tile_number == '0) ? TILE_W'(1) : i_tile_number;
            ctrl_d.i2c_set_param = 1'b1;
            ctrl_d.i2s_set_param = i_op_mode[1];
          end
        end
        S_SET_PARAM: begin
          if (i_i2c_set_param_done) begin
            c_flag_d             = 1'b1;
            ctrl_d.i2c_set_param = 1'b0;
          end
          if (i_i2s_set_param_done && mode_q[1]) begin
            s_flag_d             = 1'b1;
            ctrl_d.i2s_set_param = 1'b0;
          end
          if (c_flag_d && (s_flag_d || !mode_q[1])) begin
            state_d                  = S_CONVERT;
            ctrl_d.i2c_set_param     = 1'b0;
            ctrl_d.i2s_set_param     = 1'b0;
            ctrl_d.en_ram            = 1'b1;
            ctrl_d.i2c_enable        = 1'b1;
            ctrl_d.im2col_addressing = mode_q[0];
          end else begin
            w_timeout = w_wd_fire;
          end
        end
        S_CONVERT: begin
          if (i_i2c_convert_done) begin
            ctrl_d.en_ram = 1'b0;
            if (mode_q == MODE_POOL) begin
              state_d            = S_WAIT;
              ctrl_d.image_ready = 1'b1;
            end else begin
              state_d           = S_SYS;
              ctrl_d.i2c_read   = 1'b1;
              ctrl_d.i2s_enable = 1'b1;
            end
          end else begin
            w_timeout = w_wd_fire;
          end
        end
        S_SYS: begin
          if (i_i2c_slice_read_done) begin
            state_d            = S_WAIT;
            ctrl_d.i2c_read    = 1'b0;
            ctrl_d.i2s_enable  = 1'b0;
            ctrl_d.image_ready = 1'b1;
          end else begin
            w_timeout = w_wd_fire;
          end
        end
        S_WAIT: begin
          if (i_start_mac && mode_q[1]) begin
            state_d            = S_READ;
            ctrl_d.i2s_read    = 1'b1;
            ctrl_d.image_ready = 1'b0;
          end else if (i_start_pool && (mode_q == MODE_POOL)) begin
            state_d            = S_POOL;
            ctrl_d.i2c_read    = 1'b1;
            ctrl_d.image_ready = 1'b0;
          end
        end
        S_READ: begin
          if (i_i2s_read_done) begin
            state_d         = S_CHECK;
            ctrl_d.i2s_read = 1'b0;
            ctrl_d.done     = 1'b1;
          end else begin
            w_timeout = w_wd_fire;
          end
        end
        S_CHECK: begin
          // Remaining tiles reuse the slice already resident in the array.
          if (tile_idx_q < (tile_cnt_q - TILE_W'(1))) begin
            tile_idx_d         = tile_idx_q + TILE_W'(1);
            state_d            = S_WAIT;
            ctrl_d.image_ready = 1'b1;
          end else begin
            tile_idx_d = '0;
            if (slice_idx_q == (slice_cnt_q - SLICE_W'(1))) begin
              state_d = S_DONE;
            end else begin
              slice_idx_d       = slice_idx_q + SLICE_W'(1);
              state_d           = S_SYS;
              ctrl_d.i2c_read   = 1'b1;
              ctrl_d.i2s_enable = 1'b1;
            end
          end
        end
        S_POOL: begin
          if (i_i2c_read_done) begin
            state_d         = S_DONE;
            ctrl_d.i2c_read = 1'b0;
          end else begin
            w_timeout = w_wd_fire;
          end
        end
        default: ;
      endcase

      if (w_timeout) begin
        state_d                  = S_ERROR;
        ctrl_d.error             = 1'b1;
        ctrl_d.i2c_set_param     = 1'b0;
        ctrl_d.i2s_set_param     = 1'b0;
        ctrl_d.i2c_enable        = 1'b0;
        ctrl_d.i2c_read          = 1'b0;
        ctrl_d.i2s_enable        = 1'b0;
        ctrl_d.i2s_read          = 1'b0;
        ctrl_d.en_ram            = 1'b0;
        ctrl_d.im2col_addressing = 1'b0;
      end
    end

    ctrl_d.busy = (state_d != S_IDLE);
    if (state_d != S_SET_PARAM) begin
      c_flag_d = 1'b0;
      s_flag_d = 1'b0;
    end
    wd_d = ((state_d != state_q) || !w_watched) ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      mode_q      <= '0;
      slice_cnt_q <= '0;
      tile_cnt_q  <= '0;
      slice_idx_q <= '0;
      tile_idx_q  <= '0;
      c_flag_q    <= 1'b0;
      s_flag_q    <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      mode_q      <= mode_d;
      slice_cnt_q <= slice_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      slice_idx_q <= slice_idx_d;
      tile_idx_q  <= tile_idx_d;
      c_flag_q    <= c_flag_d;
      s_flag_q    <= s_flag_d;
      wd_q        <= wd_d;
    end
  end

  assign o_i2c_set_param     = ctrl_q.i2c_set_param;
  assign o_i2s_set_param     = ctrl_q.i2s_set_param;
  assign o_i2c_enable        = ctrl_q.i2c_enable;
  assign o_i2c_read          = ctrl_q.i2c_read;
  assign o_i2s_enable        = ctrl_q.i2s_enable;
  assign o_i2s_read          = ctrl_q.i2s_read;
  assign o_en_ram            = ctrl_q.en_ram;
  assign o_im2col_addressing = ctrl_q.im2col_addressing;
  assign o_image_ready       = ctrl_q.image_ready;
  assign o_done              = ctrl_q.done;
  assign o_busy              = ctrl_q.busy;
  assign o_error             = ctrl_q.error;
  assign o_slice_idx         = slice_idx_q;
  assign o_tile_idx          = tile_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_im2col_sequencer.sv
`default_nettype none
// ============================================================================
// tb_im2col_sequencer
//   Bench acting as the datapath: answers the sequencer with randomly delayed
//   handshakes and checks every job against counts derived from slices/tiles.
//   Revision: 1.0
// ============================================================================

module tb_im2col_sequencer;

  localparam int SETP = 0, SMAC = 1, SPOOL = 2, TERM = 3, C_SPD = 4;
  localparam int S_SPD = 5, CONV_D = 6, SLICE_D = 7, C_RD = 8, S_RD = 9;

  logic        i_clk = 1'b0;
  logic        i_n_reset = 1'b0;
  logic [9:0]  strobe = '0;
  logic [1:0]  i_op_mode = '0;
  logic [15:0] i_slice_number = '0;
  logic [7:0]  i_tile_number = '0;

  logic o_i2c_set_param, o_i2s_set_param, o_i2c_enable, o_i2c_read;
  logic o_i2s_enable, o_i2s_read, o_en_ram, o_im2col_addressing;
  logic o_image_ready, o_done, o_busy, o_error;
  logic [15:0] o_slice_idx;
  logic [7:0]  o_tile_idx;

  always #5 i_clk = ~i_clk;

  im2col_sequencer #(.SLICE_W(16), .TILE_W(8), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset),
    .i_set_param(strobe[SETP]), .i_start_mac(strobe[SMAC]),
    .i_start_pool(strobe[SPOOL]), .i_terminate(strobe[TERM]),
    .i_op_mode(i_op_mode), .i_slice_number(i_slice_number), .i_tile_number(i_tile_number),
    .i_i2c_set_param_done(strobe[C_SPD]), .i_i2s_set_param_done(strobe[S_SPD]),
    .i_i2c_convert_done(strobe[CONV_D]), .i_i2c_slice_read_done(strobe[SLICE_D]),
    .i_i2c_read_done(strobe[C_RD]), .i_i2s_read_done(strobe[S_RD]),
    .o_i2c_set_param(o_i2c_set_param), .o_i2s_set_param(o_i2s_set_param),
    .o_i2c_enable(o_i2c_enable), .o_i2c_read(o_i2c_read),
    .o_i2s_enable(o_i2s_enable), .o_i2s_read(o_i2s_read),
    .o_en_ram(o_en_ram), .o_im2col_addressing(o_im2col_addressing),
    .o_image_ready(o_image_ready), .o_done(o_done), .o_busy(o_busy), .o_error(o_error),
    .o_slice_idx(o_slice_idx), .o_tile_idx(o_tile_idx)
  );

  wire [35:0] w_all = {o_i2c_set_param, o_i2s_set_param, o_i2c_enable, o_i2c_read,
                       o_i2s_enable, o_i2s_read, o_en_ram, o_im2col_addressing,
                       o_image_ready, o_done, o_busy, o_error, o_slice_idx, o_tile_idx};

  int vecs = 0, errs = 0;
  int n_done = 0, n_rdy = 0, n_sys = 0, n_i2s = 0;
  logic rdy_prev = 1'b0, sen_prev = 1'b0;

  // Event counters observed just after each active edge.
  always @(posedge i_clk) begin
    #1;
    if (o_done) n_done++;
    if (o_image_ready && !rdy_prev) n_rdy++;
    if (o_i2s_enable && !sen_prev) n_sys++;
    if (o_i2s_enable || o_i2s_read || o_i2s_set_param) n_i2s++;
    rdy_prev = o_image_ready;
    sen_prev = o_i2s_enable;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse(input int k);
    strobe    = '0;
    strobe[k] = 1'b1;
    @(negedge i_clk);
    strobe = '0;
  endtask

  task automatic test_reset;
    i_n_reset = 1'b0;
    tick(2);
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL reset_outputs: got %h want 0", w_all); end
    i_n_reset = 1'b1;
    tick(1);
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL post_reset_idle: got %h want 0", w_all); end
  endtask

  // Drives a job from IDLE through parameter setup and conversion.
  task automatic start_job(input logic [1:0] mode, input int sl, input int tl);
    int first;
    i_op_mode = mode; i_slice_number = 16'(sl); i_tile_number = 8'(tl);
    pulse(SETP);
    vecs++; if ({o_busy, o_i2c_set_param, o_i2s_set_param} !== {2'b11, mode[1]}) begin
      errs++; $display("FAIL set_param_out: got %b want %b", {o_busy, o_i2c_set_param, o_i2s_set_param}, {2'b11, mode[1]}); end
    if (mode[1]) begin
      first = int'($urandom_range(0, 1));
      tick(int'($urandom_range(0, 2)));
      pulse(first == 1 ? S_SPD : C_SPD);
      vecs++; if ({o_en_ram, o_i2c_set_param, o_i2s_set_param} !== (first == 1 ? 3'b010 : 3'b001)) begin
        errs++; $display("FAIL sticky_drop: got %b want %b", {o_en_ram, o_i2c_set_param, o_i2s_set_param}, (first == 1 ? 3'b010 : 3'b001)); end
      tick(int'($urandom_range(0, 2)));
      pulse(first == 1 ? C_SPD : S_SPD);
    end else begin
      tick(int'($urandom_range(0, 2)));
      pulse(C_SPD);
    end
    vecs++; if ({o_en_ram, o_i2c_enable, o_im2col_addressing, o_i2c_set_param, o_i2s_set_param} !== {2'b11, mode[0], 2'b00}) begin
      errs++; $display("FAIL convert_entry: got %b want %b", {o_en_ram, o_i2c_enable, o_im2col_addressing, o_i2c_set_param, o_i2s_set_param}, {2'b11, mode[0], 2'b00}); end
    tick(int'($urandom_range(0, 2)));
    pulse(CONV_D);
    vecs++; if ({o_en_ram, o_image_ready, o_i2c_read, o_i2s_enable} !== (mode[1] ? 4'b0011 : 4'b0100)) begin
      errs++; $display("FAIL convert_exit: got %b want %b", {o_en_ram, o_image_ready, o_i2c_read, o_i2s_enable}, (mode[1] ? 4'b0011 : 4'b0100)); end
  endtask

  task automatic run_job(input logic [1:0] mode, input int sl, input int tl);
    int es, et, d0, r0, y0, i0;
    es = (sl == 0) ? 1 : sl;
    et = (tl == 0) ? 1 : tl;
    d0 = n_done; r0 = n_rdy; y0 = n_sys; i0 = n_i2s;
    start_job(mode, sl, tl);
    if (mode == 2'b01) begin
      pulse(SMAC);
      vecs++; if ({o_image_ready, o_i2c_read} !== 2'b10) begin errs++; $display("FAIL pool_ignores_mac: got %b want 10", {o_image_ready, o_i2c_read}); end
      tick(int'($urandom_range(0, 2)));
      pulse(SPOOL);
      vecs++; if ({o_image_ready, o_i2c_read} !== 2'b01) begin errs++; $display("FAIL pool_start: got %b want 01", {o_image_ready, o_i2c_read}); end
      tick(int'($urandom_range(0, 2)));
      pulse(C_RD);
      tick(3);
      vecs++; if ({o_i2c_read, o_busy, o_done, o_error} !== 4'b0100) begin errs++; $display("FAIL pool_done: got %b want 0100", {o_i2c_read, o_busy, o_done, o_error}); end
      vecs++; if ((n_i2s - i0) != 0 || (n_rdy - r0) != 1) begin errs++; $display("FAIL pool_counts: got i2s=%0d rdy=%0d want 0 1", n_i2s - i0, n_rdy - r0); end
    end else begin
      for (int k = 0; k < es * et; k++) begin
        if (k % et == 0) begin
          tick(int'($urandom_range(0, 2)));
          pulse(SLICE_D);
        end
        pulse(SPOOL);
        vecs++; if ({o_image_ready, o_i2s_read} !== 2'b10) begin errs++; $display("FAIL wait_state k=%0d: got %b want 10", k, {o_image_ready, o_i2s_read}); end
        tick(int'($urandom_range(0, 2)));
        pulse(SMAC);
        vecs++; if ({o_image_ready, o_i2s_read} !== 2'b01) begin errs++; $display("FAIL mac_start k=%0d: got %b want 01", k, {o_image_ready, o_i2s_read}); end
        tick(int'($urandom_range(0, 2)));
        pulse(S_RD);
        vecs++; if ({o_done, o_i2s_read, o_slice_idx, o_tile_idx} !== {2'b10, 16'(k / et), 8'(k % et)}) begin
          errs++; $display("FAIL done_pulse k=%0d: got done=%b slice=%0d tile=%0d want 1 %0d %0d", k, o_done, o_slice_idx, o_tile_idx, k / et, k % et); end
        tick(1);
        if (k < es * et - 1) begin
          vecs++; if ({o_i2c_read, o_i2s_enable, o_slice_idx, o_tile_idx} !== {((k + 1) % et == 0) ? 2'b11 : 2'b00, 16'((k + 1) / et), 8'((k + 1) % et)}) begin
            errs++; $display("FAIL advance k=%0d: got rd=%b en=%b slice=%0d tile=%0d want slice %0d tile %0d", k, o_i2c_read, o_i2s_enable, o_slice_idx, o_tile_idx, (k + 1) / et, (k + 1) % et); end
        end
      end
      tick(3);
      vecs++; if ({o_busy, o_done, o_error, o_slice_idx, o_tile_idx} !== {3'b100, 16'(es - 1), 8'h0}) begin
        errs++; $display("FAIL job_done: got busy=%b done=%b slice=%0d tile=%0d want 1 0 %0d 0", o_busy, o_done, o_slice_idx, o_tile_idx, es - 1); end
      vecs++; if ((n_done - d0) != es * et || (n_rdy - r0) != es * et || (n_sys - y0) != es) begin
        errs++; $display("FAIL job_counts: got done=%0d rdy=%0d sys=%0d want %0d %0d %0d", n_done - d0, n_rdy - r0, n_sys - y0, es * et, es * et, es); end
    end
    pulse(TERM);
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL terminate_clear: got %h want 0", w_all); end
  endtask

  task automatic test_nop_and_idle;
    i_op_mode = 2'b00;
    pulse(SETP);
    pulse(S_RD);
    pulse(CONV_D);
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL nop_ignored: got %h want 0", w_all); end
  endtask

  task automatic test_param_order;
    i_op_mode = 2'b11; i_slice_number = 16'd1; i_tile_number = 8'd1;
    pulse(SETP);
    pulse(S_SPD);
    tick(2);
    vecs++; if ({o_en_ram, o_i2c_set_param, o_i2s_set_param, o_busy} !== 4'b0101) begin
      errs++; $display("FAIL order_hold: got %b want 0101", {o_en_ram, o_i2c_set_param, o_i2s_set_param, o_busy}); end
    pulse(C_SPD);
    vecs++; if ({o_en_ram, o_i2c_enable, o_i2c_set_param} !== 3'b110) begin
      errs++; $display("FAIL order_convert: got %b want 110", {o_en_ram, o_i2c_enable, o_i2c_set_param}); end
    pulse(TERM);
  endtask

  task automatic test_timeout;
    int n;
    i_op_mode = 2'b11; i_slice_number = 16'd1; i_tile_number = 8'd1;
    pulse(SETP);
    pulse(S_SPD);
    pulse(C_SPD);
    n = 0;
    while (!o_error && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    vecs++; if (n != 8) begin errs++; $display("FAIL timeout_cycles: got %0d want 8", n); end
    tick(2);
    vecs++; if ({o_error, o_en_ram, o_i2c_enable, o_im2col_addressing, o_busy} !== 5'b10001) begin
      errs++; $display("FAIL error_state: got %b want 10001", {o_error, o_en_ram, o_i2c_enable, o_im2col_addressing, o_busy}); end
    pulse(TERM);
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL error_terminate: got %h want 0", w_all); end
  endtask

  task automatic test_reset_mid;
    int d0;
    start_job(2'b11, 2, 2);
    tick(1);
    d0 = n_done;
    #2 i_n_reset = 1'b0;
    #1;
    vecs++; if (w_all !== 36'h0) begin errs++; $display("FAIL async_reset: got %h want 0", w_all); end
    @(negedge i_clk);
    i_n_reset = 1'b1;
    tick(2);
    vecs++; if (w_all !== 36'h0 || n_done != d0) begin errs++; $display("FAIL reset_release: got %h done=%0d want 0 %0d", w_all, n_done, d0); end
  endtask

  task automatic test_terminate_priority;
    int d0;
    start_job(2'b10, 1, 2);
    pulse(SLICE_D);
    pulse(SMAC);
    d0 = n_done;
    strobe = '0; strobe[TERM] = 1'b1; strobe[S_RD] = 1'b1;
    @(negedge i_clk);
    strobe = '0;
    tick(1);
    vecs++; if (w_all !== 36'h0 || n_done != d0) begin errs++; $display("FAIL term_priority: got %h done=%0d want 0 %0d", w_all, n_done, d0); end
  endtask

  initial begin
    test_reset();
    test_nop_and_idle();
    run_job(2'b11, 2, 1);
    run_job(2'b10, 1, 3);
    run_job(2'b01, 1, 1);
    run_job(2'b11, 0, 0);
    test_param_order();
    test_timeout();
    test_reset_mid();
    test_terminate_priority();
    repeat (6) begin
      run_job(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
